// File: rtl/ac_motor_pwm_pkg.sv
// Shared definitions for the three-phase PWM modulator: phase FSM encoding and defaults.
// No logic; latency n/a; backpressure n/a.
package ac_motor_pwm_pkg;

    localparam int PWM_WIDTH    = 24;
    localparam int PWM_DEADTIME = 50;
    localparam int PWM_DT_BITS  = 10;

    // Smallest counter width that can hold DEADTIME-1 while keeping 2^bits > DEADTIME.
    function automatic int dt_bits_min(input int deadtime);
        return (deadtime < 2) ? 1 : $clog2(deadtime + 1);
    endfunction

    localparam int PWM_DT_BITS_MIN = dt_bits_min(PWM_DEADTIME);

    typedef logic [1:0] phase_state_t;

    localparam logic [1:0] PH_OFF  = 2'd0;
    localparam logic [1:0] PH_HIGH = 2'd1;
    localparam logic [1:0] PH_LOW  = 2'd2;
    localparam logic [1:0] PH_DT   = 2'd3;

endpackage

// File: rtl/ac_motor_pwm_halfbridge.sv
// One half-bridge: OFF/HIGH/LOW/DT state machine with a dead-time counter between switch changes.
// Latency: gate off 1 clk after want_high flips; opposite gate on DEADTIME+1 clks after.
// Backpressure: none; run low forces OFF on the next edge, overriding every other transition.
module ac_motor_pwm_halfbridge
    import ac_motor_pwm_pkg::*;
#(
    parameter int DEADTIME = PWM_DEADTIME,
    parameter int DT_BITS  = PWM_DT_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic want_high,
    output logic gate_h,
    output logic gate_l
);

    localparam logic [DT_BITS-1:0] DT_LOAD = DT_BITS'(DEADTIME - 1);
    localparam logic [DT_BITS-1:0] DT_ONE  = DT_BITS'(1);

    phase_state_t       state;
    phase_state_t       state_nxt;
    logic [DT_BITS-1:0] dt_cnt;
    logic [DT_BITS-1:0] dt_cnt_nxt;

    always_comb begin
        state_nxt  = state;
        dt_cnt_nxt = dt_cnt;
        if (!run) begin
            state_nxt  = PH_OFF;
            dt_cnt_nxt = '0;
        end else begin
            case (state)
                PH_OFF: begin
                    state_nxt  = PH_DT;
                    dt_cnt_nxt = DT_LOAD;
                end
                PH_HIGH: begin
                    if (!want_high) begin
                        state_nxt  = PH_DT;
                        dt_cnt_nxt = DT_LOAD;
                    end
                end
                PH_LOW: begin
                    if (want_high) begin
                        state_nxt  = PH_DT;
                        dt_cnt_nxt = DT_LOAD;
                    end
                end
                default: begin
                    // A reversal while counting does not reload; the side is chosen at exit.
                    if (dt_cnt == '0) begin
                        state_nxt = want_high ? PH_HIGH : PH_LOW;
                    end else begin
                        dt_cnt_nxt = dt_cnt - DT_ONE;
                    end
                end
            endcase
        end
    end

    // Gates are decoded from the next state so they track the state register exactly,
    // which makes high and low mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PH_OFF;
            dt_cnt <= '0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_cnt_nxt;
            gate_h <= (state_nxt == PH_HIGH);
            gate_l <= (state_nxt == PH_LOW);
        end
    end

endmodule

// File: rtl/ac_motor_pwm.sv
// Three-phase PWM modulator: double-buffered references compared against the triangle carrier.
// Latency: update 1 clk after an extremum sample; gates as per half-bridge (1 clk off, DEADTIME+1 on).
// Backpressure: none; enable or lock low forces all gates off, references keep tracking.
module ac_motor_pwm
    import ac_motor_pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int DEADTIME = PWM_DEADTIME,
    parameter int DT_BITS  = PWM_DT_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    lock,
    input  logic signed [WIDTH-1:0] triangle,
    input  logic signed [WIDTH-1:0] ref_u,
    input  logic signed [WIDTH-1:0] ref_v,
    input  logic signed [WIDTH-1:0] ref_w,
    output logic                    update,
    output logic                    gate_uh,
    output logic                    gate_ul,
    output logic                    gate_vh,
    output logic                    gate_vl,
    output logic                    gate_wh,
    output logic                    gate_wl
);

    logic signed [WIDTH-1:0] tri_prev;
    logic signed [WIDTH-1:0] shadow_u;
    logic signed [WIDTH-1:0] shadow_v;
    logic signed [WIDTH-1:0] shadow_w;
    logic                    slope_up;

    logic peak;
    logic valley;
    logic extremum;
    logic run;
    logic want_u;
    logic want_v;
    logic want_w;

    // Equal consecutive samples are neither a peak nor a valley, so plateaus keep the slope.
    assign peak     = slope_up  && (triangle < tri_prev);
    assign valley   = !slope_up && (triangle > tri_prev);
    assign extremum = peak || valley;
    assign run      = enable && lock;

    always_ff @(posedge clk) begin
        if (reset) begin
            tri_prev <= '0;
            slope_up <= 1'b1;
            shadow_u <= '0;
            shadow_v <= '0;
            shadow_w <= '0;
            update   <= 1'b0;
        end else begin
            tri_prev <= triangle;
            update   <= extremum;
            if (extremum) begin
                shadow_u <= ref_u;
                shadow_v <= ref_v;
                shadow_w <= ref_w;
                slope_up <= !slope_up;
            end
        end
    end

    assign want_u = (shadow_u > triangle);
    assign want_v = (shadow_v > triangle);
    assign want_w = (shadow_w > triangle);

    ac_motor_pwm_halfbridge #(
        .DEADTIME (DEADTIME),
        .DT_BITS  (DT_BITS)
    ) u_hb_u (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .want_high (want_u),
        .gate_h    (gate_uh),
        .gate_l    (gate_ul)
    );

    ac_motor_pwm_halfbridge #(
        .DEADTIME (DEADTIME),
        .DT_BITS  (DT_BITS)
    ) u_hb_v (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .want_high (want_v),
        .gate_h    (gate_vh),
        .gate_l    (gate_vl)
    );

    ac_motor_pwm_halfbridge #(
        .DEADTIME (DEADTIME),
        .DT_BITS  (DT_BITS)
    ) u_hb_w (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .want_high (want_w),
        .gate_h    (gate_wh),
        .gate_l    (gate_wl)
    );

endmodule

// File: tb/tb_ac_motor_pwm.sv
// Directed bench for ac_motor_pwm with default parameters (WIDTH 24, DEADTIME 50).
module tb_ac_motor_pwm;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               lock;
    logic signed [23:0] triangle;
    logic signed [23:0] ref_u;
    logic signed [23:0] ref_v;
    logic signed [23:0] ref_w;
    logic               update;
    logic               gate_uh, gate_ul, gate_vh, gate_vl, gate_wh, gate_wl;
    logic [5:0]         gates;

    int n_cmp = 0;
    int n_bad = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    assign gates = {gate_uh, gate_ul, gate_vh, gate_vl, gate_wh, gate_wl};

    ac_motor_pwm dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .lock     (lock),
        .triangle (triangle),
        .ref_u    (ref_u),
        .ref_v    (ref_v),
        .ref_w    (ref_w),
        .update   (update),
        .gate_uh  (gate_uh),
        .gate_ul  (gate_ul),
        .gate_vh  (gate_vh),
        .gate_vl  (gate_vl),
        .gate_wh  (gate_wh),
        .gate_wl  (gate_wl)
    );

    always @(negedge clk) begin
        if ((gate_uh & gate_ul) | (gate_vh & gate_vl) | (gate_wh & gate_wl))
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int first;
        int tri_val;
        int dir;
        int cnt_uh, cnt_ul, cnt_off, cnt_vh, cnt_wl;
        int off_run;
        bit seen_on;

        reset = 1'b1; enable = 1'b1; lock = 1'b1;
        triangle = '0; ref_u = '0; ref_v = '0; ref_w = '0;

        // Reset held 5 cycles with a ramping carrier.
        for (int i = 0; i < 5; i++) begin
            triangle = 24'(i);
            tick();
            chk("reset_gates", 64'(gates), 64'd0);
            chk("reset_update", 64'(update), 64'd0);
        end
        reset = 1'b0;
        triangle = '0;
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (gates != 6'd0) begin first = n; break; end
        end
        chk("first_on_after_reset", 64'(first), 64'd51);
        chk("first_on_all_low", 64'(gates), 64'b010101);
        chk("no_update_flat", 64'(update), 64'd0);

        // Ramp 0,1,2,3,3,2,1: plateau keeps slope, peak on 3->2.
        triangle = 24'sd1; tick(); chk("ramp1_update", 64'(update), 64'd0);
        triangle = 24'sd2; tick();
        triangle = 24'sd3; tick();
        triangle = 24'sd3; tick(); chk("plateau_update", 64'(update), 64'd0);
        ref_u = 24'sd5;
        triangle = 24'sd2; tick();
        chk("peak_update", 64'(update), 64'd1);
        chk("peak_shadow_u", 64'(dut.shadow_u), 64'd5);
        triangle = 24'sd1; tick();
        chk("post_peak_update", 64'(update), 64'd0);
        chk("u_off_1cyc", 64'({gate_uh, gate_ul}), 64'd0);
        chk("v_stays_low", 64'(gate_vl), 64'd1);
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (gate_uh || gate_ul) begin first = n; break; end
        end
        chk("u_dt_to_high", 64'(first), 64'd50);
        chk("u_high_side", 64'(gate_uh), 64'd1);

        // Symmetric +-1000 carrier, step 10: ref_u at zero, V/W at full scale.
        ref_u = 24'sd0;
        ref_v = 24'sh7FFFFF;
        ref_w = 24'sh800000;
        tri_val = 0; dir = -1;
        cnt_uh = 0; cnt_ul = 0; cnt_off = 0; cnt_vh = 0; cnt_wl = 0;
        off_run = 0; seen_on = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            triangle = 24'(tri_val);
            tick();
            if (k >= 400) begin
                if (gate_uh) cnt_uh++;
                if (gate_ul) cnt_ul++;
                if (gate_vh) cnt_vh++;
                if (gate_wl) cnt_wl++;
                if (!gate_uh && !gate_ul) begin
                    cnt_off++;
                    off_run++;
                end else begin
                    if (seen_on && off_run != 0) chk("u_dt_gap", 64'(off_run), 64'd50);
                    off_run = 0;
                    seen_on = 1'b1;
                end
            end
            if (dir < 0 && tri_val == -1000) dir = 1;
            else if (dir > 0 && tri_val == 1000) dir = -1;
            tri_val += dir * 10;
        end
        chk("u_high_cycles", 64'(cnt_uh), 64'd298);
        chk("u_low_cycles", 64'(cnt_ul), 64'd302);
        chk("u_off_cycles", 64'(cnt_off), 64'd200);
        chk("v_full_high", 64'(cnt_vh), 64'd800);
        chk("w_full_low", 64'(cnt_wl), 64'd800);

        // Hold carrier so U sits in HIGH, then drop lock for one cycle.
        triangle = -24'sd500;
        for (int n = 0; n < 60; n++) tick();
        chk("u_high_before_lock", 64'(gates), 64'b101001);
        lock = 1'b0;
        tick();
        chk("lock_drop_gates", 64'(gates), 64'd0);
        lock = 1'b1;
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (gates != 6'd0) begin first = n; break; end
        end
        chk("lock_return_dt", 64'(first), 64'd51);
        chk("lock_return_gates", 64'(gates), 64'b101001);

        // Carrier crosses above ref, then back below during the dead time.
        triangle = 24'sd10;
        tick();
        chk("valley_update", 64'(update), 64'd1);
        chk("u_enter_dt", 64'({gate_uh, gate_ul}), 64'd0);
        for (int n = 0; n < 9; n++) tick();
        triangle = -24'sd500;
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (gate_uh || gate_ul) begin first = n; break; end
        end
        chk("dt_no_restart", 64'(first), 64'd41);
        chk("dt_exit_side", 64'({gate_uh, gate_ul}), 64'b10);

        // Enable low, then reset mid-operation.
        enable = 1'b0;
        tick();
        chk("enable_low_gates", 64'(gates), 64'd0);
        enable = 1'b1;
        reset = 1'b1;
        tick();
        chk("mid_reset_gates", 64'(gates), 64'd0);
        chk("mid_reset_update", 64'(update), 64'd0);
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (gates != 6'd0) begin first = n; break; end
        end
        chk("post_reset_dt", 64'(first), 64'd51);

        chk("no_overlap", 64'(overlap_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
